mem_load_store_unit: RTL and testbench
======================================

Name: mem_load_store_unit

Overview:
- MEM-stage initiator for the word-addressed data memory. It converts pipeline load and store requests into req/ack memory transactions.
- Supports byte, halfword and word accesses: LB/LBU/LH/LHU/LW/SB/SH/SW.
- Sub-word stores use read-modify-write. Loads are sign- or zero-extended.
- Stalls the pipeline until each transaction completes.

Parameters:
- ADDR_W, 9: word-address width driven to the data memory. Byte address bits [ADDR_W+1:2] are used.
- TIMEOUT_CYCLES, 16: number of ack-wait cycles before abort. Used only with MEM_TIMEOUT_EN.

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Reset  input  1  synchronous, active-high reset.
- MemRead_MEM  input  1  load request.
- MemWrite_MEM  input  1  store request.
- Mem_Size_MEM  input  2  00 byte, 01 half, 10 word, 11 treated as word.
- Mem_Signed_MEM  input  1  1 = sign-extend load, 0 = zero-extend.
- ALU_Result_MEM  input  32  byte address.
- Write_Data_MEM  input  32  store data; the low bits are used for sub-word stores.
- Load_Data_MEM  output  32  extended load result.
- Stall_MEM  output  1  pipeline hold.
- Misaligned_MEM  output  1  alignment fault, combinational.
- Bus_Error_MEM  output  1  timeout abort pulse.
- Mem_Req  output  1  transaction request.
- Mem_We  output  1  1 = write.
- Mem_Addr  output  ADDR_W  word address.
- Mem_Wdata  output  32  write word.
- Mem_Rdata  input  32  read word; valid in the ack cycle.
- Mem_Ack  input  1  transaction complete.

Behaviour:
- Reset: state IDLE. All outputs are 0: Mem_Req, Mem_We, Mem_Addr, Mem_Wdata, Load_Data_MEM, Stall_MEM, Misaligned_MEM, Bus_Error_MEM.
- Memory handshake:
  - Mem_Req stays high, with Mem_Addr, Mem_We and Mem_Wdata stable, until Mem_Ack is sampled high.
  - Mem_Req drops in the cycle after the ack.
  - Mem_Ack seen while Mem_Req is low is ignored.
- Alignment: a fault is half with addr[0]=1, or word with addr[1:0]≠0.
  - On a fault: no memory request, Misaligned_MEM=1 in IDLE that cycle, Stall_MEM=0, Load_Data_MEM unchanged.
- Request priority: if MemRead_MEM and MemWrite_MEM are both high, the read wins and the write is dropped.
- Stall_MEM is combinational. It is 1 when either:
  - state is IDLE and an aligned request is present, or
  - state is RD_WAIT, RMW_RD, RMW_WR or WR_WAIT.
  - It is 0 in DONE and in IDLE with no request.
- FSM:
  - IDLE:
    - aligned read → RD_WAIT.
    - aligned word write → WR_WAIT, with Mem_Wdata=Write_Data_MEM.
    - aligned sub-word write → RMW_RD.
    - Mem_Req is registered high on entry to each wait state.
  - RD_WAIT:
    - on ack, capture the extended lane into Load_Data_MEM → DONE.
  - RMW_RD (Mem_We=0):
    - on ack, merge the Write_Data_MEM byte/half into Mem_Rdata at lane addr[1:0] (byte) or addr[1] (half) → RMW_WR.
    - Mem_Req deasserts for one cycle, then reasserts with Mem_We=1 and the merged word.
  - RMW_WR / WR_WAIT:
    - on ack → DONE.
  - DONE:
    - one cycle, Stall_MEM=0 so the pipeline advances → IDLE.
- Minimum latencies with ack on the first request cycle:
  - load or word store: 3 cycles, IDLE→wait→DONE.
  - sub-word store: 5 cycles.
- Lane extraction, little-endian:
  - byte lane = addr[1:0].
  - half lane = addr[1].
  - sign extension copies bit 7 or bit 15.
- Load_Data_MEM holds its last value until the next load completes.
- Address bits above ADDR_W+1 are ignored (address wraps).
- Reset mid-transaction:
  - FSM goes to IDLE and Mem_Req drops on the next edge.
  - A late ack is ignored.
  - A partially completed RMW leaves memory unmodified, because the write had not yet been issued.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - a counter runs in every wait state.
  - if TIMEOUT_CYCLES cycles pass without ack: drop Mem_Req, pulse Bus_Error_MEM for 1 cycle, set Load_Data_MEM=0, go to DONE.
  - the counter clears on ack, on state entry, and on Reset.
- Undefined:
  - no counter; waits indefinitely.
  - Bus_Error_MEM is tied to 0.

Test Plan:
- LW at 0x0000_0010, memory word 4 = 0xDEADBEEF, ack after 2 cycles → Mem_Addr=4, Stall_MEM high 3 cycles, Load_Data_MEM=0xDEADBEEF, Misaligned_MEM=0.
- LB signed at 0x13 with word 4 = 0x80FF1234 → Load_Data_MEM=0xFFFFFF80. Same access as LBU → 0x00000080.
- SB 0xAB at 0x11 with word 4 = 0x11223344 → a read, then a write of 0x1122AB44. Mem_Req low for one cycle between the two. Total 5 cycles with immediate acks.
- LH at 0x0000_0003 → no Mem_Req, Misaligned_MEM=1 in that cycle, Stall_MEM=0, Load_Data_MEM unchanged.
- Reset asserted during RMW_RD before ack, then ack arrives → state IDLE, Mem_Req=0 next cycle, no write issued, memory word unchanged.
- With MEM_TIMEOUT_EN and no ack, LW → Bus_Error_MEM pulses after 16 wait cycles, Load_Data_MEM=0, Stall_MEM released.

Source files
------------

// File: rtl/mem_load_store_unit.sv
// mem_load_store_unit: MEM-stage initiator turning pipeline loads/stores into
// req/ack transactions on a word-addressed data memory.
//   - LB/LBU/LH/LHU/LW/SB/SH/SW; sub-word stores use read-modify-write.
//   - Pipeline side: MemRead_MEM, MemWrite_MEM, Mem_Size_MEM, Mem_Signed_MEM,
//     ALU_Result_MEM (byte address), Write_Data_MEM -> Load_Data_MEM,
//     Stall_MEM (comb), Misaligned_MEM (comb), Bus_Error_MEM.
//   - Memory side: Mem_Req, Mem_We, Mem_Addr, Mem_Wdata <- Mem_Rdata, Mem_Ack.
//   - Clk, Reset: synchronous active-high reset.
// Optional: define MEM_TIMEOUT_EN to abort a wait after TIMEOUT_CYCLES
// cycles without ack (Bus_Error_MEM pulse); otherwise waits forever.
module mem_load_store_unit #(
  parameter int unsigned ADDR_W         = 9,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              MemRead_MEM,
  input  logic              MemWrite_MEM,
  input  logic [1:0]        Mem_Size_MEM,
  input  logic              Mem_Signed_MEM,
  input  logic [31:0]       ALU_Result_MEM,
  input  logic [31:0]       Write_Data_MEM,
  output logic [31:0]       Load_Data_MEM,
  output logic              Stall_MEM,
  output logic              Misaligned_MEM,
  output logic              Bus_Error_MEM,
  output logic              Mem_Req,
  output logic              Mem_We,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [31:0]       Mem_Wdata,
  input  logic [31:0]       Mem_Rdata,
  input  logic              Mem_Ack
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_WAIT = 3'd1;
  localparam logic [2:0] S_RMW_RD  = 3'd2;
  localparam logic [2:0] S_RMW_WR  = 3'd3;
  localparam logic [2:0] S_WR_WAIT = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        lane_q, lane_d;
  logic              sign_q, sign_d;
  logic [15:0]       wsub_q, wsub_d;
  logic              req_d, we_d, berr_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       wdata_d, load_d;

  logic has_req, misal, ack_ok, in_wait;
  logic unused_ok;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Upper address bits are ignored so the address wraps.
  assign unused_ok = ^{ALU_Result_MEM[31:ADDR_W+2], 32'(TIMEOUT_CYCLES)};

  assign has_req = MemRead_MEM | MemWrite_MEM;
  assign misal   = (Mem_Size_MEM == 2'b01) ? ALU_Result_MEM[0]
                 : (Mem_Size_MEM[1] ? (ALU_Result_MEM[1:0] != 2'b00) : 1'b0);
  // An ack only counts while a request is actually outstanding.
  assign ack_ok  = Mem_Ack & Mem_Req;
  assign in_wait = (state_q == S_RD_WAIT) || (state_q == S_RMW_RD) ||
                   (state_q == S_RMW_WR)  || (state_q == S_WR_WAIT);

  assign Stall_MEM      = ~Reset & (((state_q == S_IDLE) & has_req & ~misal) | in_wait);
  assign Misaligned_MEM = ~Reset & (state_q == S_IDLE) & has_req & misal;

  // Little-endian lane extraction with optional sign extension.
  function automatic logic [31:0] extend_lane(input logic [31:0] word, input logic [1:0] size,
                                              input logic sgn, input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   return {{24{sgn & b[7]}}, b};
      2'b01:   return {{16{sgn & h[15]}}, h};
      default: return word;
    endcase
  endfunction

  // Insert store byte/half into the word read back from memory.
  function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] lane, input logic [15:0] data);
    logic [31:0] m;
    m = word;
    if (size == 2'b00) m[{lane, 3'b000} +: 8]  = data[7:0];
    else               m[{lane[1], 4'b0000} +: 16] = data;
    return m;
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    lane_d  = lane_q;
    sign_d  = sign_q;
    wsub_d  = wsub_q;
    req_d   = Mem_Req;
    we_d    = Mem_We;
    addr_d  = Mem_Addr;
    wdata_d = Mem_Wdata;
    load_d  = Load_Data_MEM;
    berr_d  = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (has_req && !misal) begin
          addr_d = ALU_Result_MEM[ADDR_W+1:2];
          size_d = Mem_Size_MEM;
          lane_d = ALU_Result_MEM[1:0];
          sign_d = Mem_Signed_MEM;
          wsub_d = Write_Data_MEM[15:0];
          req_d  = 1'b1;
          if (MemRead_MEM) begin
            we_d    = 1'b0;
            state_d = S_RD_WAIT;
          end else if (Mem_Size_MEM[1]) begin
            we_d    = 1'b1;
            wdata_d = Write_Data_MEM;
            state_d = S_WR_WAIT;
          end else begin
            we_d    = 1'b0;
            state_d = S_RMW_RD;
          end
        end
      end
      S_RD_WAIT: begin
        if (ack_ok) begin
          load_d  = extend_lane(Mem_Rdata, size_q, sign_q, lane_q);
          req_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_RMW_RD: begin
        if (ack_ok) begin
          wdata_d = merge_lane(Mem_Rdata, size_q, lane_q, wsub_q);
          req_d   = 1'b0;
          state_d = S_RMW_WR;
        end
      end
      S_RMW_WR: begin
        // First cycle here has Mem_Req low; the write is issued on the next.
        if (!Mem_Req) begin
          req_d = 1'b1;
          we_d  = 1'b1;
        end else if (ack_ok) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = S_DONE;
        end
      end
      S_WR_WAIT: begin
        if (ack_ok) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef MEM_TIMEOUT_EN
    // Ack wait watchdog; cleared on ack and on every state change.
    if (!in_wait || ack_ok || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
      cnt_d   = '0;
      req_d   = 1'b0;
      we_d    = 1'b0;
      berr_d  = 1'b1;
      load_d  = 32'h0;
      state_d = S_DONE;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
`endif
  end

  // State and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      size_q        <= 2'b00;
      lane_q        <= 2'b00;
      sign_q        <= 1'b0;
      wsub_q        <= 16'h0;
      Mem_Req       <= 1'b0;
      Mem_We        <= 1'b0;
      Mem_Addr      <= '0;
      Mem_Wdata     <= 32'h0;
      Load_Data_MEM <= 32'h0;
      Bus_Error_MEM <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      size_q        <= size_d;
      lane_q        <= lane_d;
      sign_q        <= sign_d;
      wsub_q        <= wsub_d;
      Mem_Req       <= req_d;
      Mem_We        <= we_d;
      Mem_Addr      <= addr_d;
      Mem_Wdata     <= wdata_d;
      Load_Data_MEM <= load_d;
      Bus_Error_MEM <= berr_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_load_store_unit.sv
// Self-checking bench for mem_load_store_unit: a word memory responder with
// programmable ack delay, a behavioural model (memory image + load value +
// expected stall length per access), and a per-cycle output compare.
module tb_mem_load_store_unit;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned TO     = 16;

  logic              clk;
  logic              Reset;
  logic              MemRead_MEM, MemWrite_MEM, Mem_Signed_MEM;
  logic [1:0]        Mem_Size_MEM;
  logic [31:0]       ALU_Result_MEM, Write_Data_MEM;
  logic [31:0]       Load_Data_MEM;
  logic              Stall_MEM, Misaligned_MEM, Bus_Error_MEM;
  logic              Mem_Req, Mem_We;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [31:0]       Mem_Wdata;
  logic [31:0]       Mem_Rdata;
  logic              Mem_Ack;

  mem_load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
    .Clk(clk), .Reset(Reset),
    .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
    .Mem_Size_MEM(Mem_Size_MEM), .Mem_Signed_MEM(Mem_Signed_MEM),
    .ALU_Result_MEM(ALU_Result_MEM), .Write_Data_MEM(Write_Data_MEM),
    .Load_Data_MEM(Load_Data_MEM), .Stall_MEM(Stall_MEM),
    .Misaligned_MEM(Misaligned_MEM), .Bus_Error_MEM(Bus_Error_MEM),
    .Mem_Req(Mem_Req), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr),
    .Mem_Wdata(Mem_Wdata), .Mem_Rdata(Mem_Rdata), .Mem_Ack(Mem_Ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- memory responder ----------------
  logic [31:0] mem [512];
  bit          mem_ready = 1'b0;
  int          ack_dly   = 0;
  logic        force_ack = 1'b0;
  int          req_cnt   = 0;
  int          proto_err = 0;
  int          cyc       = 0;
  logic [ADDR_W-1:0] hold_addr;
  logic              hold_we;
  logic [31:0]       hold_wdata;
  logic              log_we    [64];
  logic [ADDR_W-1:0] log_addr  [64];
  logic [31:0]       log_wdata [64];
  int                log_cyc   [64];
  int                log_n = 0;

  // Drive ack/rdata mid-cycle; request must stay stable until acked.
  always @(negedge clk) begin
    if (Mem_Req) begin
      if (req_cnt > 0 && (Mem_Addr !== hold_addr || Mem_We !== hold_we || Mem_Wdata !== hold_wdata))
        proto_err++;
      hold_addr  = Mem_Addr;
      hold_we    = Mem_We;
      hold_wdata = Mem_Wdata;
      Mem_Ack    = force_ack || (req_cnt >= ack_dly);
      Mem_Rdata  = mem[Mem_Addr];
      req_cnt++;
    end else begin
      req_cnt   = 0;
      Mem_Ack   = force_ack;
      Mem_Rdata = 32'h0;
    end
  end

  // Commit writes and log completed transactions.
  always @(posedge clk) begin
    cyc++;
    if (!mem_ready) begin
      foreach (mem[i]) mem[i] = 32'h0;
      mem_ready = 1'b1;
    end
    if (Mem_Req && Mem_Ack) begin
      if (Mem_We) mem[Mem_Addr] = Mem_Wdata;
      if (log_n < 64) begin
        log_we[log_n]    = Mem_We;
        log_addr[log_n]  = Mem_Addr;
        log_wdata[log_n] = Mem_Wdata;
        log_cyc[log_n]   = cyc;
        log_n++;
      end
    end
  end

  // ---------------- model and checking ----------------
  logic [31:0] exp_mem [512];
  logic [31:0] exp_load;
  logic        exp_stall, exp_mis, exp_berr;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // One clock: compare outputs at the falling edge, then move past the rising edge.
  task automatic tick();
    @(negedge clk);
    chk("stall", 32'(Stall_MEM), 32'(exp_stall));
    chk("misaligned", 32'(Misaligned_MEM), 32'(exp_mis));
    chk("load_data", Load_Data_MEM, exp_load);
    chk("bus_error", 32'(Bus_Error_MEM), 32'(exp_berr));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [1:0] size, input logic sgn);
    logic [31:0] sh;
    sh = word >> (8 * addr[1:0]);
    if (size == 2'b00) return sgn ? 32'($signed(sh[7:0]))  : {24'h0, sh[7:0]};
    if (size == 2'b01) return sgn ? 32'($signed(sh[15:0])) : {16'h0, sh[15:0]};
    return word;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] addr,
                                              input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] mask;
    if (size[1]) return wd;
    mask = ((size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << (8 * addr[1:0]);
    return (old & ~mask) | ((wd << (8 * addr[1:0])) & mask);
  endfunction

  task automatic drive(input logic rd, input logic wr, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] wd);
    MemRead_MEM = rd; MemWrite_MEM = wr; Mem_Size_MEM = size;
    Mem_Signed_MEM = sgn; ALU_Result_MEM = addr; Write_Data_MEM = wd;
  endtask

  task automatic do_op(input logic rd, input logic wr, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd, input int dly);
    int          widx, base, n, exp_n;
    logic        misal, is_rd, sub;
    logic [31:0] newv;
    widx  = int'((addr >> 2) & 32'd511);
    misal = (size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00);
    is_rd = rd;
    sub   = !rd && size[1] == 1'b0;
    base  = log_n;
    ack_dly = dly;
    drive(rd, wr, size, sgn, addr, wd);
    if (misal) begin
      exp_stall = 1'b0; exp_mis = 1'b1;
      tick();
      exp_n = 0;
    end else begin
      n = sub ? 2 * dly + 4 : dly + 2;
      exp_stall = 1'b1; exp_mis = 1'b0;
      repeat (n) tick();
      newv = model_store(exp_mem[widx], addr, size, wd);
      if (is_rd) exp_load = model_load(exp_mem[widx], addr, size, sgn);
      else exp_mem[widx] = newv;
      exp_stall = 1'b0;
      tick();
      exp_n = sub ? 2 : 1;
    end
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    exp_mis = 1'b0;
    tick();
    tick();
    chk("txn_count", 32'(log_n - base), 32'(exp_n));
    if (exp_n > 0 && log_n >= base + exp_n) begin
      chk("txn0_addr", 32'(log_addr[base]), 32'(widx));
      chk("txn0_we", 32'(log_we[base]), 32'(!is_rd && !sub));
      if (!is_rd && !sub) chk("txn0_wdata", log_wdata[base], exp_mem[widx]);
      if (sub) begin
        chk("txn1_addr", 32'(log_addr[base+1]), 32'(widx));
        chk("txn1_we", 32'(log_we[base+1]), 32'd1);
        chk("txn1_wdata", log_wdata[base+1], exp_mem[widx]);
        chk("rmw_gap", 32'(log_cyc[base+1] - log_cyc[base]), 32'(dly + 2));
      end
    end
    chk("mem_word", mem[widx], exp_mem[widx]);
    chk("protocol", 32'(proto_err), 32'd0);
  endtask

  initial begin
    int base;
    foreach (exp_mem[i]) exp_mem[i] = 32'h0;
    exp_load = 32'h0; exp_stall = 1'b0; exp_mis = 1'b0; exp_berr = 1'b0;
    Reset = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    // Reset state, literal.
    chk("rst_req", 32'(Mem_Req), 32'd0);
    chk("rst_we", 32'(Mem_We), 32'd0);
    chk("rst_addr", 32'(Mem_Addr), 32'd0);
    chk("rst_wdata", Mem_Wdata, 32'h0);
    tick();
    Reset = 1'b0;
    tick();

    do_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 0);   // SW
    do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 1);           // LW, ack after 2
    chk("lw_lit", Load_Data_MEM, 32'hDEAD_BEEF);
    chk("lw_addr_lit", 32'(log_addr[log_n-1]), 32'd4);
    do_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h80FF_1234, 0);
    do_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0, 0);           // LB
    chk("lb_lit", Load_Data_MEM, 32'hFFFF_FF80);
    do_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0, 2);           // LBU
    chk("lbu_lit", Load_Data_MEM, 32'h0000_0080);
    do_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h1122_3344, 0);
    do_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'hFFFF_FFAB, 0);   // SB (RMW)
    chk("sb_lit", mem[4], 32'h1122_AB44);
    do_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0003, 32'h0, 0);           // LH misaligned
    chk("misal_hold_lit", Load_Data_MEM, 32'h0000_0080);
    do_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h1234_BEEF, 1);   // SH upper half
    do_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0022, 32'h0, 0);           // LH
    chk("lh_lit", Load_Data_MEM, 32'hFFFF_BEEF);
    do_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0020, 32'h0, 0);           // LHU
    do_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0023, 32'h0000_007F, 0);   // SB lane 3
    do_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0023, 32'h0, 1);
    do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0012, 32'h0, 0);           // LW misaligned
    do_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0011, 32'h5555_5555, 0);   // SW misaligned
    do_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0021, 32'h0000_5555, 0);   // SH misaligned
    do_op(1'b1, 1'b0, 2'b11, 1'b1, 32'h0000_0010, 32'h0, 0);           // size 11 = word
    do_op(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h0000_0000, 0);   // read wins
    do_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0814, 32'hCAFE_F00D, 0);   // wraps to word 5
    do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0014, 32'h0, 0);
    chk("wrap_lit", Load_Data_MEM, 32'hCAFE_F00D);
    do_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0, 0);           // LHU upper
    chk("lhu_lit", Load_Data_MEM, 32'h0000_1122);

    // Reset during RMW read, then a late ack while idle.
    base = log_n;
    ack_dly = 10;
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h0000_0099);
    exp_stall = 1'b1;
    tick();
    tick();
    Reset = 1'b1;
    exp_stall = 1'b0;
    tick();
    Reset = 1'b0;
    exp_load = 32'h0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    force_ack = 1'b1;
    repeat (3) begin
      chk("late_ack_req", 32'(Mem_Req), 32'd0);
      tick();
    end
    force_ack = 1'b0;
    tick();
    chk("rst_txn_count", 32'(log_n - base), 32'd0);
    chk("rst_mem_lit", mem[4], 32'h1122_AB44);
    ack_dly = 0;
    do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 0);           // recovery

`ifdef MEM_TIMEOUT_EN
    // No ack at all: abort after TO wait cycles.
    base = log_n;
    ack_dly = 100000;
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
    exp_stall = 1'b1;
    repeat (TO + 1) tick();
    exp_stall = 1'b0; exp_berr = 1'b1; exp_load = 32'h0;
    tick();
    exp_berr = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    tick();
    chk("timeout_req", 32'(Mem_Req), 32'd0);
    chk("timeout_txn", 32'(log_n - base), 32'd0);
    chk("timeout_load_lit", Load_Data_MEM, 32'h0);
    ack_dly = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
